// File: rtl/ray_triangle_scheduler_pkg.sv
// Shared types and constants for the ray/triangle intersection front end.
package rt_pkg;

    localparam int unsigned D_BITS = 32;
    localparam int unsigned M_BITS = 12;
    localparam int unsigned Q_BITS = 16;

    // Three signed fixed-point components, index 0 = x.
    typedef logic signed [2:0][D_BITS-1:0] vec3_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CAPTURE,
        CREDIT,
        ISSUE,
        FLUSH,
        DRAIN,
        DONE
    } sched_state_t;

endpackage

// File: rtl/ray_triangle_scheduler_credit_counter.sv
// Rays-in-flight counter: +1 per ray start, -1 per returned result, sticky underflow flag.
module credit_counter #(
    parameter int unsigned MAX_INFLIGHT = 4,
    parameter int unsigned CNT_BITS     = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_inc,
    input  logic                i_dec,
    output logic [CNT_BITS-1:0] o_count,
    output logic                o_overflow_err
);

    logic [CNT_BITS-1:0] r_count;
    logic                r_overflow_err;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_count        <= '0;
            r_overflow_err <= 1'b0;
        end else if (i_inc && !i_dec) begin
            r_count <= r_count + CNT_BITS'(1);
        end else if (i_dec && !i_inc) begin
            // A result with nothing in flight is an upstream protocol error.
            if (r_count == '0) begin
                r_overflow_err <= 1'b1;
            end else begin
                r_count <= r_count - CNT_BITS'(1);
            end
        end
    end

    assign o_count        = r_count;
    assign o_overflow_err = r_overflow_err;

endmodule

// File: rtl/ray_triangle_scheduler.sv
// Issues one job per (ray, triangle) pair, credit-limited, then a single flush job.
module ray_triangle_scheduler
    import rt_pkg::*;
#(
    parameter int unsigned R_BITS       = 16,
    parameter int unsigned MAX_INFLIGHT = 4
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [R_BITS-1:0] i_num_rays,
    input  logic [M_BITS-1:0] i_num_triangles,
    input  logic              i_ray_empty,
    output logic              o_ray_rd_en,
    input  vec3_t             i_ray_origin,
    input  vec3_t             i_ray_dir,
    input  logic              i_job_full,
    output logic              o_job_wr_en,
    output vec3_t             o_job_origin,
    output vec3_t             o_job_dir,
    output logic [M_BITS-1:0] o_job_triangle_id,
    output logic              o_job_flush,
    input  logic              i_result_valid,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_overflow_err
);

    localparam int unsigned CNT_BITS = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CNT_BITS-1:0] MAX_CNT = CNT_BITS'(MAX_INFLIGHT);

    sched_state_t        r_state, w_state_next;
    logic [R_BITS-1:0]   r_num_rays, r_rays_issued, r_results_seen, w_results_next;
    logic [M_BITS-1:0]   r_num_tri, r_tri_cnt;
    vec3_t               r_ray_origin, r_ray_dir;
    logic                r_job_wr_en, r_job_flush;
    vec3_t               r_job_origin, r_job_dir;
    logic [M_BITS-1:0]   r_job_id;
    logic [CNT_BITS-1:0] w_inflight;
    logic                w_push_ray, w_push_flush, w_last_tri, w_ray_rd_en;

    assign w_push_ray   = (r_state == ISSUE) && !i_job_full;
    assign w_push_flush = (r_state == FLUSH) && !i_job_full;
    assign w_last_tri   = (r_tri_cnt == r_num_tri - M_BITS'(1));

    assign w_results_next = (i_result_valid && (r_results_seen != r_num_rays))
                          ? r_results_seen + R_BITS'(1) : r_results_seen;

    credit_counter #(
        .MAX_INFLIGHT (MAX_INFLIGHT),
        .CNT_BITS     (CNT_BITS)
    ) u_credit (
        .i_clock        (i_clock),
        .i_reset        (i_reset),
        .i_inc          (w_push_ray && (r_tri_cnt == '0)),
        .i_dec          (i_result_valid),
        .o_count        (w_inflight),
        .o_overflow_err (o_overflow_err)
    );

    always_comb begin
        w_state_next = r_state;
        w_ray_rd_en  = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    if ((i_num_rays == '0) || (i_num_triangles == '0)) begin
                        w_state_next = DONE;
                    end else begin
                        w_state_next = FETCH;
                    end
                end
            end
            FETCH: begin
                if (!i_ray_empty) begin
                    w_ray_rd_en  = 1'b1;
                    w_state_next = CAPTURE;
                end
            end
            CAPTURE: w_state_next = CREDIT;
            CREDIT:  if (w_inflight < MAX_CNT) w_state_next = ISSUE;
            ISSUE: begin
                if (w_push_ray && w_last_tri) begin
                    w_state_next = (r_rays_issued + R_BITS'(1) < r_num_rays) ? FETCH : FLUSH;
                end
            end
            FLUSH:   if (!i_job_full) w_state_next = DRAIN;
            // Include this cycle's result so done follows the last result by one cycle.
            DRAIN:   if (w_results_next == r_num_rays) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state        <= IDLE;
            r_num_rays     <= '0;
            r_num_tri      <= '0;
            r_tri_cnt      <= '0;
            r_rays_issued  <= '0;
            r_results_seen <= '0;
            r_ray_origin   <= '0;
            r_ray_dir      <= '0;
            r_job_wr_en    <= 1'b0;
            r_job_flush    <= 1'b0;
            r_job_origin   <= '0;
            r_job_dir      <= '0;
            r_job_id       <= '0;
        end else begin
            r_state        <= w_state_next;
            r_results_seen <= w_results_next;
            r_job_wr_en    <= w_push_ray || w_push_flush;
            if ((r_state == IDLE) && i_start) begin
                r_num_rays     <= i_num_rays;
                r_num_tri      <= i_num_triangles;
                r_rays_issued  <= '0;
                r_results_seen <= '0;
            end
            if (r_state == CAPTURE) begin
                r_ray_origin <= i_ray_origin;
                r_ray_dir    <= i_ray_dir;
                r_tri_cnt    <= '0;
            end
            if (w_push_ray) begin
                r_job_origin <= r_ray_origin;
                r_job_dir    <= r_ray_dir;
                r_job_id     <= r_tri_cnt;
                r_job_flush  <= 1'b0;
                r_tri_cnt    <= r_tri_cnt + M_BITS'(1);
                if (w_last_tri) begin
                    r_rays_issued <= r_rays_issued + R_BITS'(1);
                end
            end
            if (w_push_flush) begin
                r_job_origin <= '0;
                r_job_dir    <= '0;
                r_job_id     <= '0;
                r_job_flush  <= 1'b1;
            end
        end
    end

    assign o_ray_rd_en       = w_ray_rd_en;
    assign o_job_wr_en       = r_job_wr_en;
    assign o_job_origin      = r_job_origin;
    assign o_job_dir         = r_job_dir;
    assign o_job_triangle_id = r_job_id;
    assign o_job_flush       = r_job_flush;
    assign o_busy            = (r_state != IDLE);
    assign o_done            = (r_state == DONE);

endmodule

// File: tb/tb_ray_triangle_scheduler.sv
// Directed bench for ray_triangle_scheduler with MAX_INFLIGHT = 2.
module tb_ray_triangle_scheduler;
    import rt_pkg::*;

    typedef struct packed {
        logic              flush;
        logic [M_BITS-1:0] id;
        vec3_t             origin;
        vec3_t             dir;
    } job_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [15:0]       num_rays = '0;
    logic [M_BITS-1:0] num_tri = '0;
    logic              ray_empty = 1'b0;
    logic              ray_rd_en;
    vec3_t             ray_origin, ray_dir;
    logic              job_full = 1'b0;
    logic              job_wr_en;
    vec3_t             job_origin, job_dir;
    logic [M_BITS-1:0] job_id;
    logic              job_flush;
    logic              result_valid = 1'b0;
    logic              busy, done, overflow_err;

    logic [31:0] pop_cnt;
    job_t        jobs[$];
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    ray_triangle_scheduler #(
        .R_BITS       (16),
        .MAX_INFLIGHT (2)
    ) dut (
        .i_clock           (clk),
        .i_reset           (rst),
        .i_start           (start),
        .i_num_rays        (num_rays),
        .i_num_triangles   (num_tri),
        .i_ray_empty       (ray_empty),
        .o_ray_rd_en       (ray_rd_en),
        .i_ray_origin      (ray_origin),
        .i_ray_dir         (ray_dir),
        .i_job_full        (job_full),
        .o_job_wr_en       (job_wr_en),
        .o_job_origin      (job_origin),
        .o_job_dir         (job_dir),
        .o_job_triangle_id (job_id),
        .o_job_flush       (job_flush),
        .i_result_valid    (result_valid),
        .o_busy            (busy),
        .o_done            (done),
        .o_overflow_err    (overflow_err)
    );

    // Ray source: after k pops the FIFO head shows ray k.
    function automatic vec3_t exp_origin(input logic [31:0] k);
        vec3_t v;
        v[0] = k;
        v[1] = -k;
        v[2] = k * 32'd3;
        return v;
    endfunction

    function automatic vec3_t exp_dir(input logic [31:0] k);
        vec3_t v;
        v[0] = k + 32'd100;
        v[1] = 32'd7;
        v[2] = -(k + 32'd100);
        return v;
    endfunction

    assign ray_origin = exp_origin(pop_cnt);
    assign ray_dir    = exp_dir(pop_cnt);

    always @(posedge clk or posedge rst) begin
        if (rst) pop_cnt <= '0;
        else if (ray_rd_en) pop_cnt <= pop_cnt + 32'd1;
    end

    always @(negedge clk) begin
        if (job_wr_en) jobs.push_back({job_flush, job_id, job_origin, job_dir});
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_job(input string tag, input int k, input logic flush,
                           input logic [M_BITS-1:0] id);
        logic [127:0] obs;
        obs = (k < jobs.size()) ? 128'({jobs[k].flush, jobs[k].id}) : 'x;
        chk(tag, obs, 128'({flush, id}));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        result_valid = 1'b0;
        job_full = 1'b0;
        step();
        step();
        rst = 1'b0;
        jobs.delete();
        step();
    endtask

    task automatic start_run(input logic [15:0] rays, input logic [M_BITS-1:0] tris);
        num_rays = rays;
        num_tri  = tris;
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    task automatic wait_jobs(input int n, input int budget);
        for (int i = 0; i < budget && jobs.size() < n; i++) step();
        chk("job_count", 128'(jobs.size()), 128'(n));
    endtask

    task automatic send_results(input int n);
        result_valid = 1'b1;
        for (int i = 0; i < n; i++) step();
        result_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !done; i++) step();
        chk("done_seen", 128'(done), 128'(1));
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_outputs", 128'({job_wr_en, job_flush, busy, done, ray_rd_en, overflow_err}),
            128'(0));
        chk("rst_job_id", 128'(job_id), 128'(0));

        // 1: one ray, three triangles, then flush; done one cycle after the result
        start_run(16'd1, 12'd3);
        chk("t1_busy", 128'(busy), 128'(1));
        chk("t1_rd_en", 128'(ray_rd_en), 128'(1));
        wait_jobs(4, 20);
        chk_job("t1_job0", 0, 1'b0, 12'd0);
        chk_job("t1_job1", 1, 1'b0, 12'd1);
        chk_job("t1_job2", 2, 1'b0, 12'd2);
        chk_job("t1_flush", 3, 1'b1, 12'd0);
        if (jobs.size() >= 4) begin
            chk("t1_origin", 128'(jobs[1].origin), 128'(exp_origin(32'd1)));
            chk("t1_dir", 128'(jobs[2].dir), 128'(exp_dir(32'd1)));
            chk("t1_flush_origin", 128'({jobs[3].origin, jobs[3].dir}), 128'(0));
        end
        chk("t1_no_early_done", 128'({busy, done}), 128'(2'b10));
        result_valid = 1'b1;
        step();
        result_valid = 1'b0;
        chk("t1_done_pulse", 128'({busy, done}), 128'(2'b11));
        step();
        chk("t1_done_clear", 128'({busy, done}), 128'(2'b00));
        chk("t1_no_overflow", 128'(overflow_err), 128'(0));

        // 2: credit stall after two rays; one result releases the third
        do_reset();
        start_run(16'd3, 12'd2);
        for (int i = 0; i < 19; i++) step();
        chk("t2_stall_jobs", 128'(jobs.size()), 128'(4));
        chk("t2_stall_pops", 128'(pop_cnt), 128'(3));
        chk_job("t2_r1_id0", 2, 1'b0, 12'd0);
        chk_job("t2_r1_id1", 3, 1'b0, 12'd1);
        send_results(1);
        wait_jobs(7, 20);
        chk_job("t2_r2_id0", 4, 1'b0, 12'd0);
        chk_job("t2_r2_id1", 5, 1'b0, 12'd1);
        chk_job("t2_flush", 6, 1'b1, 12'd0);
        chk("t2_not_done", 128'(done), 128'(0));
        send_results(2);
        wait_done(4);

        // 3: job_full for 5 cycles while ID 1 is pending
        do_reset();
        start_run(16'd1, 12'd4);
        for (int i = 0; i < 4; i++) step();
        chk("t3_id0_push", 128'({job_wr_en, job_id}), 128'({1'b1, 12'd0}));
        job_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3_stalled_wr", 128'(job_wr_en), 128'(0));
        end
        job_full = 1'b0;
        step();
        chk("t3_id1_push", 128'({job_wr_en, job_id}), 128'({1'b1, 12'd1}));
        wait_jobs(5, 20);
        for (int k = 0; k < 4; k++) chk_job("t3_seq", k, 1'b0, 12'(k));
        chk_job("t3_flush", 4, 1'b1, 12'd0);
        send_results(1);
        wait_done(4);

        // 4: result coincides with ray 2's ID-0 push; ray 3 must not stall
        do_reset();
        start_run(16'd4, 12'd2);
        for (int i = 0; i < 19; i++) step();
        chk("t4_stall_jobs", 128'(jobs.size()), 128'(4));
        send_results(1);
        step();
        result_valid = 1'b1;
        step();
        result_valid = 1'b0;
        chk("t4_r2_id0", 128'({job_wr_en, job_id}), 128'({1'b1, 12'd0}));
        wait_jobs(9, 20);
        chk_job("t4_r3_id1", 7, 1'b0, 12'd1);
        chk_job("t4_flush", 8, 1'b1, 12'd0);
        send_results(2);
        wait_done(4);
        step();
        chk("t4_no_overflow", 128'(overflow_err), 128'(0));
        send_results(1);
        chk("t4_overflow", 128'(overflow_err), 128'(1));

        // 5: zero triangles goes straight to done
        do_reset();
        start_run(16'd5, 12'd0);
        chk("t5_done", 128'({busy, done, ray_rd_en}), 128'(3'b110));
        step();
        chk("t5_idle", 128'({busy, done}), 128'(2'b00));
        chk("t5_no_work", 128'({pop_cnt, 32'(jobs.size())}), 128'(0));

        // 6: reset during ISSUE at ID 5, then a clean run
        do_reset();
        start_run(16'd1, 12'd8);
        for (int i = 0; i < 8; i++) step();
        chk("t6_id4_push", 128'({job_wr_en, job_id}), 128'({1'b1, 12'd4}));
        rst = 1'b1;
        step();
        chk("t6_rst_ctrl", 128'({job_wr_en, job_flush, busy, done, ray_rd_en, overflow_err}),
            128'(0));
        chk("t6_rst_data", 128'({job_id, job_origin, job_dir}), 128'(0));
        rst = 1'b0;
        step();
        jobs.delete();
        start_run(16'd1, 12'd2);
        wait_jobs(3, 20);
        chk_job("t6_id0", 0, 1'b0, 12'd0);
        chk_job("t6_id1", 1, 1'b0, 12'd1);
        chk_job("t6_flush", 2, 1'b1, 12'd0);
        if (jobs.size() >= 1) chk("t6_origin", 128'(jobs[0].origin), 128'(exp_origin(32'd1)));
        send_results(1);
        wait_done(4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
